// File: rtl/sdram_frontend_pkg.sv
// -----------------------------------------------------------------------------
// sdram_frontend_pkg
// Shared types and field widths for the SDRAM request front end:
//   - cmd_op_t   : command opcode presented to sdram_controller
//   - host_req_t : one buffered host request {write, addr, wdata, be}
//   - cmd_t      : the registered command channel payload
// The linear host address is {bank, row, col}; host_to_cmd() splits it.
// -----------------------------------------------------------------------------
package sdram_frontend_pkg;

  localparam int BANK_W = 2;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 9;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int ADDR_W = BANK_W + ROW_W + COL_W;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'd0,
    CMD_READ    = 2'd1,
    CMD_WRITE   = 2'd2,
    CMD_REFRESH = 2'd3
  } cmd_op_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } host_req_t;

  typedef struct packed {
    cmd_op_t           op;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   dqm;
  } cmd_t;

  localparam cmd_t CMD_IDLE = '0;

  // Refresh carries no address or data; all byte lanes masked.
  localparam cmd_t CMD_REFRESH_WORD = '{
    op:    CMD_REFRESH,
    bank:  '0,
    row:   '0,
    col:   '0,
    wdata: '0,
    dqm:   '1
  };

  // Host request -> controller command. DQM is the inverse of the byte enables.
  function automatic cmd_t host_to_cmd(input host_req_t req);
    cmd_t c;
    c.op                 = req.write ? CMD_WRITE : CMD_READ;
    {c.bank, c.row, c.col} = req.addr;
    c.wdata              = req.wdata;
    c.dqm                = ~req.be;
    return c;
  endfunction

endpackage

// File: rtl/sdram_req_fifo.sv
// -----------------------------------------------------------------------------
// sdram_req_fifo
// Small synchronous FIFO holding host_req_t entries in strict arrival order.
// Full/empty come from (log2(DEPTH)+1)-bit pointers; the extra MSB tells a
// full buffer from an empty one when the index bits match.
// Ports:
//   clock, reset   : clock, asynchronous active-high reset (pointers only)
//   push_i         : write push_data_i (ignored when full)
//   push_data_i    : entry to store
//   pop_i          : discard head entry (ignored when empty)
//   pop_data_o     : current head entry (valid when !empty_o)
//   full_o/empty_o : occupancy flags, derived from registered pointers only
// -----------------------------------------------------------------------------
module sdram_req_fifo
  import sdram_frontend_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      push_i,
  input  host_req_t push_data_i,
  input  logic      pop_i,
  output host_req_t pop_data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  host_req_t      mem_q [DEPTH];
  logic           do_push, do_pop;

  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign wr_ptr_d = do_push ? wr_ptr_q + (PTR_W+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = do_pop  ? rd_ptr_q + (PTR_W+1)'(1) : rd_ptr_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are meaningful, so clearing the array would only add reset fan-out.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data_i;
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/sdram_request_frontend.sv
// -----------------------------------------------------------------------------
// sdram_request_frontend
// Host-side front end for sdram_controller. Buffers host read/write requests
// in sdram_req_fifo, generates periodic auto-refresh demands, and arbitrates
// both onto one registered valid/ready command channel.
//
// Optional feature: define SDRAM_FRONTEND_STATS_EN to add stat_reads,
// stat_writes and stat_refreshes (32-bit wrapping handshake counters).
//
// Ports:
//   clock, reset          : clock, asynchronous active-high reset
//   init_done             : controller initialisation complete (level)
//   host_req_*            : host request channel (valid/ready), addr is
//                           {bank[1:0], row[12:0], col[8:0]}
//   cmd_valid/cmd_ready   : command channel handshake
//   cmd_op/bank/row/col   : opcode (NOP/READ/WRITE/REFRESH) and address fields
//   cmd_wdata/cmd_dqm     : write data and DQM mask (~byte enables)
//   refresh_overflow      : sticky, a refresh demand was dropped at saturation
// -----------------------------------------------------------------------------
module sdram_request_frontend
  import sdram_frontend_pkg::*;
#(
  parameter int clock_frequency     = 100_000_000,
  parameter int refresh_interval_ns = 7_812,
  parameter int fifo_depth          = 4,
  parameter int max_pending_refresh = 8,
  parameter int refresh_urgent      = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               init_done,
  input  logic               host_req_valid,
  output logic               host_req_ready,
  input  logic               host_req_write,
  input  logic [ADDR_W-1:0]  host_req_addr,
  input  logic [DATA_W-1:0]  host_req_wdata,
  input  logic [BE_W-1:0]    host_req_be,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [1:0]         cmd_op,
  output logic [BANK_W-1:0]  cmd_bank,
  output logic [ROW_W-1:0]   cmd_row,
  output logic [COL_W-1:0]   cmd_col,
  output logic [DATA_W-1:0]  cmd_wdata,
  output logic [BE_W-1:0]    cmd_dqm,
  output logic               refresh_overflow
`ifdef SDRAM_FRONTEND_STATS_EN
  ,
  output logic [31:0]        stat_reads,
  output logic [31:0]        stat_writes,
  output logic [31:0]        stat_refreshes
`endif
);

  localparam int CLOCK_PERIOD_NS = 1_000_000_000 / clock_frequency;
  localparam int INTERVAL_CYCLES = refresh_interval_ns / CLOCK_PERIOD_NS;
  localparam int TIMER_W = (INTERVAL_CYCLES > 1) ? $clog2(INTERVAL_CYCLES) : 1;
  localparam int PEND_W  = $clog2(max_pending_refresh + 1);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(INTERVAL_CYCLES - 1);
  localparam logic [PEND_W-1:0]  PEND_MAX   = PEND_W'(max_pending_refresh);
  localparam logic [PEND_W-1:0]  PEND_URG   = PEND_W'(refresh_urgent);

  typedef enum logic {
    ST_WAIT_INIT = 1'b0,
    ST_RUN       = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               ovf_q, ovf_d;
  cmd_t               cmd_q, cmd_d;
  logic               cmd_valid_q, cmd_valid_d;

  logic               running, tick, cmd_hs, refresh_hs, held_refresh, load;
  logic [PEND_W-1:0]  pend_free;
  host_req_t          push_req, fifo_head;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign running        = (state_q == ST_RUN);
  assign host_req_ready = running && !fifo_full;
  assign fifo_push      = host_req_valid && host_req_ready;
  assign push_req       = '{write: host_req_write, addr: host_req_addr,
                            wdata: host_req_wdata, be: host_req_be};

  sdram_req_fifo #(
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (fifo_push),
    .push_data_i (push_req),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign cmd_hs       = cmd_valid_q && cmd_ready;
  assign refresh_hs   = cmd_hs && (cmd_q.op == CMD_REFRESH);
  assign held_refresh = cmd_valid_q && (cmd_q.op == CMD_REFRESH);
  // Demands not yet represented on the interface; a held REFRESH is already
  // spoken for, so counting it again would issue one refresh too many.
  assign pend_free    = pend_q - {{(PEND_W-1){1'b0}}, held_refresh};
  assign load         = running && (!cmd_valid_q || cmd_ready);

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    timer_d     = '0;
    tick        = 1'b0;
    pend_d      = pend_q;
    ovf_d       = ovf_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    fifo_pop    = 1'b0;

    if (state_q == ST_WAIT_INIT && init_done) begin
      state_d = ST_RUN;
    end

    if (running) begin
      tick    = (timer_q == TIMER_LAST);
      timer_d = tick ? '0 : timer_q + TIMER_W'(1);
    end

    // A tick and a completed refresh in the same cycle cancel out.
    if (tick && !refresh_hs) begin
      if (pend_q == PEND_MAX) begin
        ovf_d = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (!tick && refresh_hs) begin
      pend_d = pend_q - PEND_W'(1);
    end

    if (load) begin
      if ((pend_free >= PEND_URG) || ((pend_free != '0) && fifo_empty)) begin
        cmd_d       = CMD_REFRESH_WORD;
        cmd_valid_d = 1'b1;
      end else if (!fifo_empty) begin
        cmd_d       = host_to_cmd(fifo_head);
        cmd_valid_d = 1'b1;
        fifo_pop    = 1'b1;
      end else begin
        cmd_d       = CMD_IDLE;
        cmd_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_WAIT_INIT;
      timer_q     <= '0;
      pend_q      <= '0;
      ovf_q       <= 1'b0;
      cmd_q       <= CMD_IDLE;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  assign cmd_valid        = cmd_valid_q;
  assign cmd_op           = cmd_q.op;
  assign cmd_bank         = cmd_q.bank;
  assign cmd_row          = cmd_q.row;
  assign cmd_col          = cmd_q.col;
  assign cmd_wdata        = cmd_q.wdata;
  assign cmd_dqm          = cmd_q.dqm;
  assign refresh_overflow = ovf_q;

`ifdef SDRAM_FRONTEND_STATS_EN
  logic [31:0] stat_reads_q, stat_writes_q, stat_refreshes_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_reads_q     <= '0;
      stat_writes_q    <= '0;
      stat_refreshes_q <= '0;
    end else if (cmd_hs) begin
      case (cmd_q.op)
        CMD_READ:    stat_reads_q     <= stat_reads_q + 32'd1;
        CMD_WRITE:   stat_writes_q    <= stat_writes_q + 32'd1;
        CMD_REFRESH: stat_refreshes_q <= stat_refreshes_q + 32'd1;
        default:     ;
      endcase
    end
  end

  assign stat_reads     = stat_reads_q;
  assign stat_writes    = stat_writes_q;
  assign stat_refreshes = stat_refreshes_q;
`endif

endmodule

// File: tb/tb_sdram_request_frontend.sv
// -----------------------------------------------------------------------------
// tb_sdram_request_frontend
// Scoreboard bench for sdram_request_frontend. Accepted host requests are
// converted to expected commands and queued; a negedge monitor pops and
// compares on every command handshake. Refresh demand is modelled as a
// saturating count of timer ticks derived from elapsed RUN cycles.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sdram_request_frontend;

  localparam int INTERVAL = 7_812 / (1_000_000_000 / 100_000_000);  // 781
  localparam int MAX_PEND = 8;
  localparam logic [1:0] OP_READ = 2'd1, OP_WRITE = 2'd2, OP_REFRESH = 2'd3;

  logic        clock = 1'b0;
  logic        reset, init_done;
  logic        host_req_valid, host_req_ready, host_req_write;
  logic [23:0] host_req_addr;
  logic [31:0] host_req_wdata;
  logic [3:0]  host_req_be;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op, cmd_bank;
  logic [12:0] cmd_row;
  logic [8:0]  cmd_col;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_dqm;
  logic        refresh_overflow;
`ifdef SDRAM_FRONTEND_STATS_EN
  logic [31:0] stat_reads, stat_writes, stat_refreshes;
`endif

  always #5 clock = ~clock;

  sdram_request_frontend dut (
    .clock            (clock),
    .reset            (reset),
    .init_done        (init_done),
    .host_req_valid   (host_req_valid),
    .host_req_ready   (host_req_ready),
    .host_req_write   (host_req_write),
    .host_req_addr    (host_req_addr),
    .host_req_wdata   (host_req_wdata),
    .host_req_be      (host_req_be),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_bank         (cmd_bank),
    .cmd_row          (cmd_row),
    .cmd_col          (cmd_col),
    .cmd_wdata        (cmd_wdata),
    .cmd_dqm          (cmd_dqm),
    .refresh_overflow (refresh_overflow)
`ifdef SDRAM_FRONTEND_STATS_EN
    ,
    .stat_reads       (stat_reads),
    .stat_writes      (stat_writes),
    .stat_refreshes   (stat_refreshes)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  bank;
    logic [12:0] row;
    logic [8:0]  col;
    logic [31:0] wdata;
    logic [3:0]  dqm;
  } exp_cmd_t;

  exp_cmd_t   exp_q[$];
  logic [1:0] log_op[$];
  longint     log_cyc[$];
  exp_cmd_t   last_host;

  longint cyc = 0;
  bit     model_run = 0;
  int     timer_m = 0, pend_m = 0, ticks_m = 0, refresh_issued = 0;
  bit     ovf_m = 0;
  bit     idle_mode = 0;
  int     stall = 0, max_stall = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor + reference model, evaluated mid-cycle on values about to be
  // sampled by the next rising edge.
  always @(negedge clock) begin
    exp_cmd_t e;
    if (reset) begin
      model_run = 0; timer_m = 0; pend_m = 0; ovf_m = 0; stall = 0;
      exp_q.delete();
    end else begin
      if (cmd_valid && cmd_ready) begin
        log_op.push_back(cmd_op);
        log_cyc.push_back(cyc);
        if (cmd_op == OP_REFRESH) begin
          refresh_issued++;
          check("refresh_demanded", pend_m > 0, 1);
          check("refresh_addr_zero", {cmd_bank, cmd_row, cmd_col}, 0);
          check("refresh_wdata_zero", cmd_wdata, 0);
          check("refresh_dqm", cmd_dqm, 4'hF);
          if (pend_m > 0) pend_m--;
        end else if (exp_q.size() == 0) begin
          check("host_cmd_expected", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("cmd_op", cmd_op, e.op);
          check("cmd_bank", cmd_bank, e.bank);
          check("cmd_row", cmd_row, e.row);
          check("cmd_col", cmd_col, e.col);
          check("cmd_wdata", cmd_wdata, e.wdata);
          check("cmd_dqm", cmd_dqm, e.dqm);
          last_host = '{cmd_op, cmd_bank, cmd_row, cmd_col, cmd_wdata, cmd_dqm};
        end
      end
      if (host_req_valid && host_req_ready) begin
        e.op    = host_req_write ? OP_WRITE : OP_READ;
        e.bank  = 2'(host_req_addr / (1 << 22));
        e.row   = 13'((host_req_addr / 512) % 8192);
        e.col   = 9'(host_req_addr % 512);
        e.wdata = host_req_wdata;
        e.dqm   = ~host_req_be;
        exp_q.push_back(e);
      end
      if (model_run) begin
        if (timer_m == INTERVAL - 1) begin
          timer_m = 0;
          ticks_m++;
          if (pend_m == MAX_PEND) ovf_m = 1; else pend_m++;
        end else begin
          timer_m++;
        end
      end else if (init_done) begin
        model_run = 1;
        timer_m = 0;
      end
      if (idle_mode) begin
        stall = (pend_m > 0) ? stall + 1 : 0;
        if (stall > max_stall) max_stall = stall;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic rand_req();
    host_req_write = 1'($urandom_range(0, 1));
    host_req_addr  = 24'($urandom);
    host_req_wdata = $urandom;
    host_req_be    = 4'($urandom);
  endtask

  task automatic send_current(input int budget);
    bit ok;
    ok = 0;
    host_req_valid = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock);
      ok = host_req_ready;
      @(posedge clock);
      #1;
    end
    host_req_valid = 1'b0;
    if (!ok) check("send_accepted", ok, 1);
  endtask

  task automatic wait_ticks(input int n, input string name);
    int target;
    target = ticks_m + n;
    for (int i = 0; i < n * INTERVAL + 20 && ticks_m < target; i++) step(1);
    if (ticks_m < target) check(name, ticks_m, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, r0, t0;
    logic [62:0] snap;

    reset = 1'b1; init_done = 1'b0; cmd_ready = 1'b1; host_req_valid = 1'b0;
    host_req_write = 1'b1; host_req_addr = 24'hC0_1234;
    host_req_wdata = 32'hDEADBEEF; host_req_be = 4'b0011;
    #12 reset = 1'b0;
    step(1);
    check("reset_ready", host_req_ready, 0);
    check("reset_cmd_valid", cmd_valid, 0);
    check("reset_cmd_op", cmd_op, 0);
    check("reset_fields", {cmd_bank, cmd_row, cmd_col, cmd_dqm}, 0);
    check("reset_overflow", refresh_overflow, 0);

    // WAIT_INIT: request offered but never accepted.
    host_req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (i % 25 == 24) begin
        check("wait_init_ready", host_req_ready, 0);
        check("wait_init_cmd_valid", cmd_valid, 0);
      end
    end
    init_done = 1'b1;
    check("ready_before_init_sampled", host_req_ready, 0);
    step(1);
    check("ready_after_init", host_req_ready, 1);
    step(1);
    host_req_valid = 1'b0;
    step(5);
    check("dir_op", last_host.op, OP_WRITE);
    check("dir_bank", last_host.bank, 3);
    check("dir_row", last_host.row, 13'h0009);
    check("dir_col", last_host.col, 9'h034);
    check("dir_dqm", last_host.dqm, 4'b1100);
    check("dir_wdata", last_host.wdata, 32'hDEADBEEF);

    // Idle: each tick must produce a REFRESH within 2 cycles.
    idle_mode = 1; max_stall = 0; r0 = refresh_issued; t0 = ticks_m;
    wait_ticks(3, "idle_ticks");
    step(5);
    idle_mode = 0;
    check("refresh_latency_le2", max_stall <= 2, 1);
    check("idle_refresh_count", refresh_issued - r0, ticks_m - t0);

    // Back-pressure: 4 buffered + 1 held, then a back-to-back burst.
    wait_ticks(1, "align_burst"); step(5);
    check("burst_start_idle", cmd_valid, 0);
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin rand_req(); send_current(10); end
    check("full_ready_low", host_req_ready, 0);
    check("full_cmd_held", cmd_valid, 1);
    snap = {cmd_op, cmd_bank, cmd_row, cmd_col, cmd_wdata, cmd_dqm};
    step(20);
    check("hold_stable", snap == {cmd_op, cmd_bank, cmd_row, cmd_col, cmd_wdata, cmd_dqm}, 1);
    l0 = log_op.size();
    cmd_ready = 1'b1;
    step(8);
    check("burst_count", log_op.size() - l0, 5);
    if (log_op.size() >= l0 + 5)
      check("burst_consecutive", 32'(log_cyc[l0+4] - log_cyc[l0]), 4);

    // Pre-emption: 4 demands accumulate behind a full FIFO.
    wait_ticks(1, "align_preempt"); step(5);
    cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin rand_req(); send_current(10); end
    wait_ticks(4, "preempt_ticks");
    step(3);
    l0 = log_op.size();
    cmd_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin rand_req(); send_current(20); end
    check("preempt_log_len", log_op.size() >= l0 + 3, 1);
    if (log_op.size() >= l0 + 3) begin
      check("preempt_first_is_host", log_op[l0] == OP_REFRESH, 0);
      check("preempt_refresh", log_op[l0+1], OP_REFRESH);
      check("head_after_refresh", log_op[l0+2] == OP_REFRESH, 0);
    end
    step(20);
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_pending_zero", pend_m, 0);
    check("drain_cmd_valid", cmd_valid, 0);

    // Saturation: 1 held + 9 more ticks -> 8 pending and overflow.
    wait_ticks(1, "align_overflow");
    cmd_ready = 1'b0;
    wait_ticks(9, "overflow_ticks");
    step(3);
    check("overflow_set", refresh_overflow, 1);
    check("overflow_held_refresh", cmd_op, OP_REFRESH);
    r0 = refresh_issued;
    cmd_ready = 1'b1;
    step(20);
    check("overflow_refresh_count", refresh_issued - r0, 8);
    check("overflow_then_idle", cmd_valid, 0);
    check("overflow_sticky", refresh_overflow, 1);

    // Reset with a command held on the interface.
    cmd_ready = 1'b0;
    rand_req(); send_current(10);
    rand_req(); send_current(10);
    check("pre_reset_cmd_valid", cmd_valid, 1);
    rand_req(); host_req_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("mid_reset_cmd_valid", cmd_valid, 0);
    check("mid_reset_cmd_op", cmd_op, 0);
    check("mid_reset_fields", {cmd_bank, cmd_row, cmd_col, cmd_dqm}, 0);
    check("mid_reset_wdata", cmd_wdata, 0);
    check("mid_reset_ready", host_req_ready, 0);
    check("mid_reset_overflow", refresh_overflow, 0);
    step(2);
    #2 reset = 1'b0; host_req_valid = 1'b0; cmd_ready = 1'b1;
    step(2);
    check("post_reset_ready", host_req_ready, 1);

    // Randomised mixed traffic with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      rand_req();
      host_req_valid = 1'($urandom_range(0, 1));
      cmd_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    host_req_valid = 1'b0; cmd_ready = 1'b1;
    step(30);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_pending_zero", pend_m, 0);
    check("final_overflow", refresh_overflow, ovf_m);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
